// File: rtl/mul_booth_iter.sv
// mul_booth_iter: iterative radix-4 Booth multiplier, one partial product accumulated per cycle.
// Final accumulator value is copied into a registered result one cycle after the last digit.
module mul_booth_iter #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result
);
    localparam int N  = (WIDTH + 2) / 2;
    localparam int CW = $clog2(N);
    localparam int HW = WIDTH + 4;
    localparam int AW = HW + 2 * N;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] WB   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH+1:0]   x_q, x_d;
    logic [WIDTH+2:0]   y_q, y_d;
    logic [AW-1:0]      acc_q, acc_d, acc_sh;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               accept, busy, one, two, neg;
    logic [HW-1:0]      mag, pp, sum;

    always_comb begin
        accept  = in_valid && state_q == IDLE;
        busy    = state_q == BUSY;
        one     = y_q[0] ^ y_q[1];
        two     = (y_q[2] ^ y_q[1]) & ~one;
        neg     = y_q[2] & ~(y_q[1] & y_q[0]);
        mag     = one ? {{2{x_q[WIDTH+1]}}, x_q} : two ? {x_q[WIDTH+1], x_q, 1'b0} : '0;
        pp      = neg ? ~mag : mag;
        sum     = acc_q[AW-1 -: HW] + pp + HW'(neg);
        acc_sh  = {{2{sum[HW-1]}}, sum, acc_q[2*N-1:2]};
        state_d = accept ? BUSY :
                  (busy && cnt_q == '0) ? WB :
                  state_q == WB ? DONE :
                  (state_q == DONE && out_ready) ? IDLE : state_q;
        cnt_d   = accept ? CW'(N - 1) : busy ? cnt_q - CW'(1) : cnt_q;
        x_d     = accept ? {{2{signed_op & a[WIDTH-1]}}, a} : x_q;
        y_d     = accept ? {{2{signed_op & b[WIDTH-1]}}, b, 1'b0} :
                  busy ? {{2{y_q[WIDTH+2]}}, y_q[WIDTH+2:2]} : y_q;
        acc_d   = accept ? '0 : busy ? acc_sh : acc_q;
        res_d   = state_q == WB ? acc_q[2*WIDTH-1:0] : res_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = res_q;
endmodule

// File: tb/tb_mul_booth_iter.sv
// tb_mul_booth_iter: scoreboard bench for the 64-bit iterative Booth multiplier.
module tb_mul_booth_iter;
    logic         clk = 0, resetn = 1, in_valid = 0, signed_op = 0, out_ready = 0;
    logic [63:0]  a = '0, b = '0;
    logic         in_ready, out_valid;
    logic [127:0] result;
    logic [127:0] exp_q[$];
    int           passed = 0, total = 0;

    always #5 clk = ~clk;

    mul_booth_iter #(.WIDTH(64)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .signed_op(signed_op), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result)
    );

    function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
        logic [127:0] ex, ey;
        ex = s ? {{64{x[63]}}, x} : {64'b0, x};
        ey = s ? {{64{y[63]}}, y} : {64'b0, y};
        return ex * ey;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic s);
        in_valid = 1; a = x; b = y; signed_op = s;
        exp_q.push_back(model(x, y, s));
        @(negedge clk);
        in_valid = 0; a = {$urandom, $urandom}; b = {$urandom, $urandom}; signed_op = ~s;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic take();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic test_reset();
        #2 resetn = 0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
        total++; if (result !== '0) $display("FAIL reset_result: got %h expected 0", result); else passed++;
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [63:0]  ta[4], tb[4];
        logic         ts[4];
        logic [127:0] tr[4];
        logic [127:0] e;
        int           edges;
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'hFFFF_FFFF_FFFF_FFFF; ts[0] = 0;
        tr[0] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFD; tb[1] = 64'd7; ts[1] = 1;
        tr[1] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB;
        ta[2] = 64'hFFFF_FFFF_FFFF_FFFD; tb[2] = 64'd7; ts[2] = 0;
        tr[2] = 128'h6_FFFF_FFFF_FFFF_FFEB;
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'h8000_0000_0000_0000; ts[3] = 1;
        tr[3] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], ts[i]);
            wait_valid(edges);
            total++; if (edges != 34) $display("FAIL directed%0d_latency: got %0d expected 34", i, edges); else passed++;
            e = exp_q.pop_front();
            total++; if (result !== e) $display("FAIL directed%0d_model: got %h expected %h", i, result, e); else passed++;
            total++; if (result !== tr[i]) $display("FAIL directed%0d_const: got %h expected %h", i, result, tr[i]); else passed++;
            take();
        end
    endtask

    task automatic test_random();
        logic [127:0] e;
        int           edges;
        for (int i = 0; i < 8; i++) begin
            issue({$urandom, $urandom}, (i == 0) ? 64'd0 : {$urandom, $urandom}, 1'(i % 2));
            wait_valid(edges);
            total++; if (edges != 34) $display("FAIL random%0d_latency: got %0d expected 34", i, edges); else passed++;
            e = exp_q.pop_front();
            total++; if (result !== e) $display("FAIL random%0d_result: got %h expected %h", i, result, e); else passed++;
            take();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] e, hold;
        int           edges;
        issue(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 1);
        wait_valid(edges);
        e = exp_q.pop_front();
        total++; if (result !== e) $display("FAIL bp_result: got %h expected %h", result, e); else passed++;
        hold = result;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; a = {$urandom, $urandom}; b = {$urandom, $urandom};
            @(negedge clk);
            total++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, hold})
                $display("FAIL bp_hold%0d: got v=%b r=%b %h expected v=1 r=0 %h", i, out_valid, in_ready, result, hold);
            else passed++;
        end
        in_valid = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        total++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL bp_release: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        else passed++;
    endtask

    task automatic test_reset_midop();
        logic [127:0] e;
        int           edges, seen;
        in_valid = 1; a = 64'hDEAD_BEEF_0000_0001; b = 64'h0000_0001_CAFE_F00D; signed_op = 0;
        @(negedge clk);
        in_valid = 0;
        repeat (11) @(negedge clk);
        resetn = 0;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL midop_reset: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        else passed++;
        @(negedge clk);
        resetn = 1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++; if (seen != 0) $display("FAIL midop_no_valid: got %0d valid cycles expected 0", seen); else passed++;
        issue(64'd5, 64'd6, 0);
        wait_valid(edges);
        total++; if (edges != 34) $display("FAIL midop_latency: got %0d expected 34", edges); else passed++;
        e = exp_q.pop_front();
        total++; if (result !== e) $display("FAIL midop_model: got %h expected %h", result, e); else passed++;
        total++; if (result !== 128'd30) $display("FAIL midop_30: got %h expected 30", result); else passed++;
        take();
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        int           edges;
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b1) $display("FAIL b2b%0d_ready: got %b expected 1", i, in_ready); else passed++;
            issue({$urandom, $urandom}, {$urandom, $urandom}, 1'(i == 1));
            wait_valid(edges);
            e = exp_q.pop_front();
            total++; if (result !== e) $display("FAIL b2b%0d_result: got %h expected %h", i, result, e); else passed++;
            take();
        end
        total++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); else passed++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
